// File: rtl/spi_master_cfg_if.sv
// Host-side start/data handshake of spi_master_cfg. The on-chip client uses the
// master modport and the SPI block uses the slave modport.
interface spi_master_cfg_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  cpol;
  logic                  cpha;
  logic                  lsb_first;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  new_data;
  logic                  busy;

  modport master (
    output start, data_in, cpol, cpha, lsb_first,
    input  data_out, new_data, busy
  );

  modport slave (
    input  start, data_in, cpol, cpha, lsb_first,
    output data_out, new_data, busy
  );
endinterface

// File: rtl/spi_master_cfg.sv
// SPI master with DATA_WIDTH-bit full-duplex transfers, all four CPOL/CPHA modes,
// MSB- or LSB-first order, a programmable SCK divider and an automatic chip select.
module spi_master_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_master_cfg_if.slave bus,
  input  logic            miso,
  output logic            mosi,
  output logic            sck,
  output logic            cs_n
);

  localparam int DIV_W  = $clog2(CLK_DIV) + 1;
  localparam int EDGE_W = $clog2(2 * DATA_WIDTH) + 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_HOLD,
    ST_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DIV_W-1:0]      r_div_cnt;
  logic [EDGE_W-1:0]     r_edge_cnt;
  logic                  r_cpha;
  logic                  r_lsb_first;
  logic [DATA_WIDTH-1:0] r_tx;
  logic [DATA_WIDTH-1:0] r_rx;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_sck;
  logic                  r_mosi;
  logic                  r_active;
  logic                  r_new_data;

  logic w_accept;
  logic w_tick;
  logic w_xfer_tick;
  logic w_lead;
  logic w_trail;
  logic w_last;
  logic w_shift;
  logic w_sample;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_tx(input logic [DATA_WIDTH-1:0] w,
                                                     input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_rx(input logic [DATA_WIDTH-1:0] w,
                                                     input logic b, input logic lsb);
    return lsb ? {b, w[DATA_WIDTH-1:1]} : {w[DATA_WIDTH-2:0], b};
  endfunction

  // A new transfer may begin from IDLE or straight out of DONE (back-to-back).
  assign w_accept    = bus.start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_tick      = (r_state inside {ST_SETUP, ST_XFER, ST_HOLD}) && (r_div_cnt == DIV_LAST);
  assign w_xfer_tick = w_tick && (r_state == ST_XFER);
  assign w_lead      = w_xfer_tick && !r_edge_cnt[0];
  assign w_trail     = w_xfer_tick &&  r_edge_cnt[0];
  assign w_last      = w_xfer_tick && (r_edge_cnt == EDGE_LAST);
  assign w_shift     = r_cpha ? w_lead : (w_trail && !w_last);
  assign w_sample    = r_cpha ? w_trail : w_lead;

  // NOTE: every output of a combinational block gets a default first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_SETUP;
      ST_SETUP: if (w_tick)   w_state_nxt = ST_XFER;
      ST_XFER:  if (w_last)   w_state_nxt = ST_HOLD;
      ST_HOLD:  if (w_tick)   w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = w_accept ? ST_SETUP : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees
  // the pre-edge value of every other register, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt  <= '0;
      r_edge_cnt <= '0;
    end else begin
      if (r_state == ST_IDLE || r_state == ST_DONE || r_div_cnt == DIV_LAST) begin
        r_div_cnt <= '0;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end

      if (r_state != ST_XFER) begin
        r_edge_cnt <= '0;
      end else if (w_tick) begin
        r_edge_cnt <= r_edge_cnt + 1'b1;
      end
    end
  end

  // Shift datapath. With cpha=0 the first bit goes out when the transfer is
  // accepted, so the remaining bits shift on trailing edges only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpha      <= 1'b0;
      r_lsb_first <= 1'b0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_sck       <= 1'b0;
      r_mosi      <= 1'b0;
    end else if (w_accept) begin
      r_cpha      <= bus.cpha;
      r_lsb_first <= bus.lsb_first;
      r_sck       <= bus.cpol;
      r_rx        <= '0;
      if (bus.cpha) begin
        r_tx <= bus.data_in;
      end else begin
        r_tx   <= shift_tx(bus.data_in, bus.lsb_first);
        r_mosi <= first_bit(bus.data_in, bus.lsb_first);
      end
    end else if (r_state == ST_IDLE) begin
      r_sck <= bus.cpol;
    end else begin
      if (w_xfer_tick) begin
        r_sck <= ~r_sck;
      end
      if (w_shift) begin
        r_mosi <= first_bit(r_tx, r_lsb_first);
        r_tx   <= shift_tx(r_tx, r_lsb_first);
      end
      if (w_sample) begin
        r_rx <= shift_rx(r_rx, miso, r_lsb_first);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active   <= 1'b0;
      r_new_data <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_active   <= (w_state_nxt inside {ST_SETUP, ST_XFER, ST_HOLD});
      r_new_data <= 1'b0;
      if (r_state == ST_HOLD && w_tick) begin
        r_new_data <= 1'b1;
        r_data_out <= r_rx;
      end
    end
  end

  assign sck          = r_sck;
  assign mosi         = r_mosi;
  assign cs_n         = ~r_active;
  assign bus.busy     = r_active;
  assign bus.new_data = r_new_data;
  assign bus.data_out = r_data_out;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Bench for spi_master_cfg: an 8-bit/div-2 instance against a mode-matched slave
// model (or loopback) and a 16-bit/div-1 instance in loopback.
module tb_spi_master_cfg;

  localparam int DW_A  = 8;
  localparam int DIV_A = 2;
  localparam int DW_B  = 16;
  localparam int DIV_B = 1;
  localparam int LAT_A = 1 + DIV_A * (2 * DW_A + 2);
  localparam int LAT_B = 1 + DIV_B * (2 * DW_B + 2);
  localparam int HIST  = 4096;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_master_cfg_if #(.DATA_WIDTH(DW_A)) bus_a ();
  spi_master_cfg_if #(.DATA_WIDTH(DW_B)) bus_b ();

  logic miso_a, mosi_a, sck_a, cs_n_a;
  logic miso_b, mosi_b, sck_b, cs_n_b;

  spi_master_cfg #(.DATA_WIDTH(DW_A), .CLK_DIV(DIV_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a),
    .miso(miso_a), .mosi(mosi_a), .sck(sck_a), .cs_n(cs_n_a)
  );

  spi_master_cfg #(.DATA_WIDTH(DW_B), .CLK_DIV(DIV_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b),
    .miso(miso_b), .mosi(mosi_b), .sck(sck_b), .cs_n(cs_n_b)
  );

  assign miso_b = mosi_b;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slave model: shifts its word out on the mode's shift edge and captures mosi on
  // the mode's sample edge, purely from the observed SCK/CS_N waveforms.
  logic            s_cpol = 1'b0;
  logic            s_cpha = 1'b0;
  logic            s_lsb  = 1'b0;
  logic            s_loop = 1'b1;
  logic [DW_A-1:0] s_word = '0;
  logic            s_miso = 1'b0;
  int              s_idx  = 0;
  logic            s_cap[$];

  assign miso_a = s_loop ? mosi_a : s_miso;

  function automatic logic bit_at(input logic [DW_A-1:0] w, input int k, input logic lsb);
    return lsb ? w[k] : w[DW_A-1-k];
  endfunction

  always @(negedge cs_n_a) begin
    s_idx = 0;
    s_cap.delete();
    if (!s_cpha) s_miso = bit_at(s_word, 0, s_lsb);
  end

  always @(sck_a) begin
    if (cs_n_a === 1'b0) begin
      if ((sck_a !== s_cpol) ^ s_cpha) begin
        s_cap.push_back(mosi_a);
      end else if (s_cpha) begin
        if (s_idx < DW_A) s_miso = bit_at(s_word, s_idx, s_lsb);
        s_idx++;
      end else begin
        s_idx++;
        if (s_idx < DW_A) s_miso = bit_at(s_word, s_idx, s_lsb);
      end
    end
  end

  // Per-cycle history sampled 1 time unit after each rising edge.
  int              cyc = 0;
  logic            cs_h  [HIST];
  logic            sck_h [HIST];
  logic            nd_h  [HIST];
  logic [DW_A-1:0] do_h  [HIST];
  logic            ndb_h [HIST];
  logic [DW_B-1:0] dob_h [HIST];

  always @(posedge clk) begin
    #1;
    if (cyc < HIST - 1) cyc++;
    cs_h[cyc]  = cs_n_a;
    sck_h[cyc] = sck_a;
    nd_h[cyc]  = bus_a.new_data;
    do_h[cyc]  = bus_a.data_out;
    ndb_h[cyc] = bus_b.new_data;
    dob_h[cyc] = bus_b.data_out;
  end

  // Relative cycle r of a transfer (r=1 is the first cycle after acceptance) is
  // history index base + r - 1.
  function automatic int count_nd(input int base, input int lo, input int hi, input bit on_b);
    int n = 0;
    for (int r = lo; r <= hi; r++)
      if ((on_b ? ndb_h[base+r-1] : nd_h[base+r-1]) === 1'b1) n++;
    return n;
  endfunction

  function automatic int first_nd(input int base, input int lo, input int hi, input bit on_b);
    for (int r = lo; r <= hi; r++)
      if ((on_b ? ndb_h[base+r-1] : nd_h[base+r-1]) === 1'b1) return r;
    return -1;
  endfunction

  function automatic int count_cs_low(input int base, input int lo, input int hi);
    int n = 0;
    for (int r = lo; r <= hi; r++) if (cs_h[base+r-1] === 1'b0) n++;
    return n;
  endfunction

  function automatic int last_cs_low(input int base, input int lo, input int hi);
    int last = -1;
    for (int r = lo; r <= hi; r++) if (cs_h[base+r-1] === 1'b0) last = r;
    return last;
  endfunction

  function automatic int count_cs_falls(input int base, input int lo, input int hi);
    int n = 0;
    for (int r = lo; r <= hi; r++)
      if (cs_h[base+r-2] === 1'b1 && cs_h[base+r-1] === 1'b0) n++;
    return n;
  endfunction

  function automatic int count_sck_rises(input int base, input int lo, input int hi);
    int n = 0;
    for (int r = lo; r <= hi; r++)
      if (sck_h[base+r-2] === 1'b0 && sck_h[base+r-1] === 1'b1) n++;
    return n;
  endfunction

  // Transmit order with the first bit on the wire in the MSB position.
  function automatic logic [DW_A-1:0] tx_order(input logic [DW_A-1:0] d, input logic lsb);
    logic [DW_A-1:0] r;
    for (int k = 0; k < DW_A; k++) r[DW_A-1-k] = lsb ? d[k] : d[DW_A-1-k];
    return r;
  endfunction

  function automatic logic [DW_A-1:0] cap_word();
    logic [DW_A-1:0] w = '0;
    foreach (s_cap[k]) w = {w[DW_A-2:0], s_cap[k]};
    return w;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_cfg(input logic pol, input logic pha, input logic lsb,
                         input logic loop, input logic [DW_A-1:0] sw);
    @(negedge clk);
    bus_a.cpol      = pol;
    bus_a.cpha      = pha;
    bus_a.lsb_first = lsb;
    s_cpol = pol;
    s_cpha = pha;
    s_lsb  = lsb;
    s_loop = loop;
    s_word = sw;
    idle(2);
  endtask

  task automatic start_a(input logic [DW_A-1:0] d, output int base);
    @(negedge clk);
    bus_a.data_in = d;
    bus_a.start   = 1'b1;
    @(posedge clk);
    #2;
    bus_a.start = 1'b0;
    base = cyc;
  endtask

  // One transfer against the slave model, checked against the reference rules.
  task automatic run_slave(input string tag, input logic pol, input logic pha,
                           input logic lsb, input logic [DW_A-1:0] d,
                           input logic [DW_A-1:0] sw);
    int base;
    set_cfg(pol, pha, lsb, 1'b0, sw);
    check({tag, " sck idle"}, 32'(sck_a), 32'(pol));
    start_a(d, base);
    idle(LAT_A + 2);
    check({tag, " latency"}, first_nd(base, 1, LAT_A + 3, 1'b0), LAT_A);
    check({tag, " data_out"}, 32'(bus_a.data_out), 32'(sw));
    check({tag, " mosi bits"}, 32'(cap_word()), 32'(tx_order(d, lsb)));
    check({tag, " mosi count"}, s_cap.size(), DW_A);
  endtask

  initial begin
    int base;
    logic [DW_A-1:0] rd, rs;
    logic rp, rh, rl;

    bus_a.start = 1'b0; bus_a.data_in = '0; bus_a.cpol = 1'b0;
    bus_a.cpha  = 1'b0; bus_a.lsb_first = 1'b0;
    bus_b.start = 1'b0; bus_b.data_in = '0; bus_b.cpol = 1'b0;
    bus_b.cpha  = 1'b0; bus_b.lsb_first = 1'b0;

    // Reset state
    #22;
    check("rst cs_n", 32'(cs_n_a), 32'd1);
    check("rst sck", 32'(sck_a), 32'd0);
    check("rst mosi", 32'(mosi_a), 32'd0);
    check("rst busy", 32'(bus_a.busy), 32'd0);
    check("rst new_data", 32'(bus_a.new_data), 32'd0);
    check("rst data_out", 32'(bus_a.data_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Mode 0, MSB first, loopback, 0xA5
    set_cfg(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    start_a(8'hA5, base);
    check("t1 busy", 32'(bus_a.busy), 32'd1);
    idle(LAT_A + 2);
    check("t1 new_data cycle", first_nd(base, 1, LAT_A + 3, 1'b0), LAT_A);
    check("t1 new_data count", count_nd(base, 1, LAT_A + 3, 1'b0), 1);
    check("t1 data_out", 32'(do_h[base+LAT_A-1]), 32'hA5);
    check("t1 sck rises", count_sck_rises(base, 1, LAT_A + 3), DW_A);
    check("t1 cs_n cycle0", 32'(cs_h[base-1]), 32'd1);
    check("t1 cs_n first low", 32'(cs_h[base]), 32'd0);
    check("t1 cs_n last low", last_cs_low(base, 1, LAT_A + 3), LAT_A - 1);
    check("t1 cs_n low count", count_cs_low(base, 1, LAT_A + 3), LAT_A - 1);
    check("t1 busy after", 32'(bus_a.busy), 32'd0);

    // Mode 3, LSB first, slave returns 0x81
    run_slave("t2", 1'b1, 1'b1, 1'b1, 8'h3C, 8'h81);
    check("t2 mosi literal", 32'(cap_word()), 32'b0011_1100);
    check("t2 sck idle after", 32'(sck_a), 32'd1);

    // Modes 1 and 2 against a slave returning 0x5A
    run_slave("t3 mode1", 1'b0, 1'b1, 1'b0, 8'hC3, 8'h5A);
    run_slave("t3 mode2", 1'b1, 1'b0, 1'b0, 8'h69, 8'h5A);

    // Randomised transfers
    for (int i = 0; i < 6; i++) begin
      rd = DW_A'($urandom);
      rs = DW_A'($urandom);
      rp = 1'($urandom);
      rh = 1'($urandom);
      rl = 1'($urandom);
      run_slave($sformatf("rnd%0d", i), rp, rh, rl, rd, rs);
    end

    // Start pulse and config changes mid-transfer are ignored
    set_cfg(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    start_a(8'h96, base);
    idle(9);
    bus_a.start = 1'b1; bus_a.data_in = 8'h0F; bus_a.cpha = 1'b1; bus_a.lsb_first = 1'b1;
    idle(1);
    bus_a.start = 1'b0;
    idle(LAT_A - 5);
    check("t4 new_data count", count_nd(base, 1, LAT_A + 6, 1'b0), 1);
    check("t4 new_data cycle", first_nd(base, 1, LAT_A + 6, 1'b0), LAT_A);
    check("t4 data_out", 32'(do_h[base+LAT_A-1]), 32'h96);
    check("t4 cs_n refalls", count_cs_falls(base, 2, LAT_A + 6), 0);
    check("t4 cs_n low count", count_cs_low(base, 1, LAT_A + 6), LAT_A - 1);

    // Start held through DONE gives a back-to-back second transfer
    set_cfg(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    @(negedge clk);
    bus_a.data_in = 8'h5B;
    bus_a.start   = 1'b1;
    @(posedge clk);
    #2;
    base = cyc;
    bus_a.data_in = 8'hC4;
    idle(LAT_A);
    bus_a.start = 1'b0;
    idle(LAT_A + 2);
    check("t5 new_data count", count_nd(base, 1, 2 * LAT_A + 3, 1'b0), 2);
    check("t5 first new_data", first_nd(base, 1, 2 * LAT_A + 3, 1'b0), LAT_A);
    check("t5 second new_data", first_nd(base, LAT_A + 1, 2 * LAT_A + 3, 1'b0), 2 * LAT_A);
    check("t5 word1", 32'(do_h[base+LAT_A-1]), 32'h5B);
    check("t5 word2", 32'(do_h[base+2*LAT_A-1]), 32'hC4);
    check("t5 cs_n before gap", 32'(cs_h[base+LAT_A-2]), 32'd0);
    check("t5 cs_n gap", 32'(cs_h[base+LAT_A-1]), 32'd1);
    check("t5 cs_n after gap", 32'(cs_h[base+LAT_A]), 32'd0);

    // Asynchronous reset mid-transfer
    set_cfg(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    start_a(8'h77, base);
    idle(14);
    #3 rst_n = 1'b0;
    #1;
    check("t6 cs_n", 32'(cs_n_a), 32'd1);
    check("t6 sck", 32'(sck_a), 32'd0);
    check("t6 busy", 32'(bus_a.busy), 32'd0);
    check("t6 new_data", 32'(bus_a.new_data), 32'd0);
    check("t6 data_out", 32'(bus_a.data_out), 32'd0);
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    idle(LAT_A + 5);
    check("t6 no new_data", count_nd(base, 1, cyc - base + 1, 1'b0), 0);

    // 16-bit, divide-by-1 instance in loopback
    @(negedge clk);
    bus_b.data_in = 16'hBEEF;
    bus_b.start   = 1'b1;
    @(posedge clk);
    #2;
    bus_b.start = 1'b0;
    base = cyc;
    idle(LAT_B + 2);
    check("t6b new_data cycle", first_nd(base, 1, LAT_B + 3, 1'b1), LAT_B);
    check("t6b new_data count", count_nd(base, 1, LAT_B + 3, 1'b1), 1);
    check("t6b data_out", 32'(dob_h[base+LAT_B-1]), 32'hBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
